// File: rtl/disp_refresh_sched_if.sv
// Serializer-side bus of the display refresh scheduler: frame launch, payload and completion.
interface disp_refresh_sched_if;
  logic        p2s_start;
  logic [63:0] p2s_data;
  logic [6:0]  p2s_len;
  logic        p2s_sel;
  logic        p2s_busy;
  logic        p2s_finish;

  modport master (
    output p2s_start, p2s_data, p2s_len, p2s_sel,
    input  p2s_busy, p2s_finish
  );

  modport slave (
    input  p2s_start, p2s_data, p2s_len, p2s_sel,
    output p2s_busy, p2s_finish
  );
endinterface

// File: rtl/disp_refresh_sched.sv
// Round-robin refresh scheduler sharing one serializer between LED and seven-segment frames.
// Optional macro DISP_CHANGE_DETECT_EN: also refresh a channel whenever its input changes.
module disp_refresh_sched #(
  parameter int unsigned REFRESH_CYCLES = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 led,
  input  logic [63:0]                 segment,
  disp_refresh_sched_if.master        bus,
  output logic                        sched_busy,
  output logic                        err_timeout
);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] timer;
  logic          tick;
  logic [TW-1:0] to_cnt;
  logic [1:0]    pend, set, clr, chg, req;
  logic          grant, grant_nxt, last_grant;
  logic          start_pulse, to_hit;
  logic [63:0]   data_q;
  logic [6:0]    len_q;
  logic          sel_q;

  // free-running refresh timer
  assign tick = (timer == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

`ifdef DISP_CHANGE_DETECT_EN
  logic [15:0] shadow_led;
  logic [63:0] shadow_seg;

  // a channel's own load refreshes its shadow, so its compare is masked that cycle
  assign chg[0] = (led != shadow_led)     && !(state == LOAD && grant == 1'b0);
  assign chg[1] = (segment != shadow_seg) && !(state == LOAD && grant == 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_led <= '0;
      shadow_seg <= '0;
    end else if (state == LOAD) begin
      if (grant) shadow_seg <= segment;
      else       shadow_led <= led;
    end
  end
`else
  assign chg = 2'b00;
`endif

  assign set = {2{tick}} | chg;
  assign clr = {(state == LOAD) && grant, (state == LOAD) && !grant};
  // set events are visible to the grant in the same cycle they occur
  assign req = pend | set;
  assign grant_nxt = (&req) ? ~last_grant : req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 2'b11;
    else        pend <= set | (pend & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_pulse = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE:  if (|req) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (!bus.p2s_busy) begin
               start_pulse = 1'b1;
               state_nxt   = WAIT;
             end
      WAIT:  if (bus.p2s_finish) begin
               state_nxt = IDLE;
             end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               to_hit    = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      sel_q       <= 1'b0;
    end else begin
      if (state == IDLE && |req) grant <= grant_nxt;
      to_cnt      <= (state == WAIT) ? to_cnt + 1'b1 : '0;
      err_timeout <= err_timeout | to_hit;
      // the frame and pin steering are frozen outside LOAD
      if (state == LOAD) begin
        last_grant <= grant;
        if (grant) begin
          data_q <= segment;
          len_q  <= 7'd64;
          sel_q  <= 1'b1;
        end else begin
          data_q <= {48'h0, led};
          len_q  <= 7'd16;
          sel_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.p2s_start = start_pulse;
  assign bus.p2s_data  = data_q;
  assign bus.p2s_len   = len_q;
  assign bus.p2s_sel   = sel_q;
  assign sched_busy    = (state != IDLE);
endmodule

// File: tb/tb_disp_refresh_sched.sv
// Directed scoreboard bench for disp_refresh_sched with a behavioural serializer model.
module tb_disp_refresh_sched;
  localparam int R   = 1000;
  localparam int T   = 64;
  localparam int FIN = 20;

  typedef struct {
    logic        sel;
    logic [6:0]  len;
    logic [63:0] data;
    int          cyc;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] led;
  logic [63:0] segment;
  logic        sched_busy;
  logic        err_timeout;
  logic        hold_busy;
  logic        fin_en;
  logic        ser_act;
  int          ser_cnt;
  int          cyc;
  int          tests;
  int          fails;
  frame_t      exp_q[$];

  disp_refresh_sched_if bus();

  disp_refresh_sched #(.REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .led(led), .segment(segment),
    .bus(bus), .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // serializer: busy for FIN cycles after a start, finish on the last one when enabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_act <= 1'b0;
      ser_cnt <= 0;
      cyc     <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ser_act) begin
        ser_cnt <= ser_cnt + 1;
        if (ser_cnt == FIN - 1) ser_act <= 1'b0;
      end else if (bus.p2s_start) begin
        ser_act <= 1'b1;
        ser_cnt <= 0;
      end
    end
  end

  assign bus.p2s_busy   = ser_act | hold_busy;
  assign bus.p2s_finish = ser_act && fin_en && (ser_cnt == FIN - 1);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input bit ch, input int c);
    frame_t f;
    f.sel  = ch;
    f.len  = ch ? 7'd64 : 7'd16;
    f.data = ch ? segment : {48'h0, led};
    f.cyc  = c;
    exp_q.push_back(f);
  endtask

  task automatic wait_start(input string tag, input int budget);
    frame_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.p2s_start === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_expected"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_sel"},  bus.p2s_sel,  e.sel);
        check({tag, "_len"},  bus.p2s_len,  e.len);
        check({tag, "_data"}, bus.p2s_data, e.data);
        check({tag, "_cycle"}, cyc, e.cyc);
      end
      @(negedge clk);
      check({tag, "_pulse"}, bus.p2s_start, 1'b0);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_cyc", cyc, target);
  endtask

  task automatic quiet(input string tag, input int n);
    int starts;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.p2s_start === 1'b1) starts++;
    end
    check(tag, starts, 0);
  endtask

  initial begin
    int bad;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    hold_busy = 1'b0;
    fin_en    = 1'b1;
    led       = 16'h3C5A;
    segment   = 64'h0123_4567_89AB_CDEF;

    repeat (3) @(negedge clk);
    check("rst_start", bus.p2s_start, 1'b0);
    check("rst_data",  bus.p2s_data,  64'h0);
    check("rst_len",   bus.p2s_len,   7'd0);
    check("rst_sel",   bus.p2s_sel,   1'b0);
    check("rst_busy",  sched_busy,    1'b0);
    check("rst_err",   err_timeout,   1'b0);

    // after reset: LED first, then segment
    @(posedge clk); #1 rst_n = 1'b1;
    push(1'b0, 2);
    push(1'b1, 25);
    wait_start("boot_led", 100);
    wait_start("boot_seg", 100);

    // periodic refresh: exactly one LED+segment pair per period
    push(1'b0, 1001);
    push(1'b1, 1024);
    push(1'b0, 2001);
    push(1'b1, 2024);
    wait_start("per1_led", 1100);
    wait_start("per1_seg", 100);
    wait_start("per2_led", 1100);
    wait_start("per2_seg", 100);

    // serializer busy while in START
    wait_cyc(2990);
    @(posedge clk); #1 hold_busy = 1'b1;
    wait_cyc(3000);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.p2s_start !== 1'b0 || sched_busy !== 1'b1) bad++;
    end
    check("busy_hold", bad, 0);
    @(posedge clk); #1 hold_busy = 1'b0;
    push(1'b0, 3051);
    push(1'b1, 3074);
    wait_start("busy_led", 10);
    wait_start("busy_seg", 100);

    // missing finish: timeout, then the pending segment frame
    wait_cyc(3200);
    @(posedge clk); #1 fin_en = 1'b0;
    push(1'b0, 4001);
    wait_start("to_led", 1000);
    wait_cyc(4030);
    @(posedge clk); #1 fin_en = 1'b1;
    wait_cyc(4065);
    check("to_err_before", err_timeout, 1'b0);
    check("to_busy_before", sched_busy, 1'b1);
    @(negedge clk);
    check("to_err_set", err_timeout, 1'b1);
    check("to_idle", sched_busy, 1'b0);
    push(1'b1, 4068);
    wait_start("to_seg", 10);

    // reset in the middle of a frame
    wait_cyc(4075);
    check("err_sticky", err_timeout, 1'b1);
    check("wait_busy", sched_busy, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("mid_rst_start", bus.p2s_start, 1'b0);
    check("mid_rst_data",  bus.p2s_data,  64'h0);
    check("mid_rst_len",   bus.p2s_len,   7'd0);
    check("mid_rst_sel",   bus.p2s_sel,   1'b0);
    check("mid_rst_busy",  sched_busy,    1'b0);
    check("mid_rst_err",   err_timeout,   1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(1'b0, 2);
    push(1'b1, 25);
    wait_start("rst2_led", 100);
    wait_start("rst2_seg", 100);

    wait_cyc(100);
`ifdef DISP_CHANGE_DETECT_EN
    @(posedge clk); #1 led = 16'h0000;
    push(1'b0, 103);
    wait_start("chg_zero", 10);
    wait_cyc(150);
    @(posedge clk); #1 led = 16'hA5A5;
    push(1'b0, 153);
    wait_start("chg_a5a5", 10);
    quiet("chg_no_seg", 200);
`else
    @(posedge clk); #1 led = 16'hA5A5;
    quiet("nochg_quiet", 300);
`endif
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
